// File: rtl/cam_param.sv
// cam_param: writable DEPTH x DATA_W content-addressable memory for port lookup.
// Registered one-cycle lookup with lowest-index priority and a multi-hit flag.
// A sequenced flush clears one entry per cycle while ready is low.
// Optional feature macro: CAM_TERNARY_EN adds a per-entry care mask (wr_mask port).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | accepting writes, invalidates, lookups and flush requests
//   S_FLUSH | clearing valid[r_idx] each cycle, all requests ignored
module cam_param #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef CAM_TERNARY_EN
    input  logic [DATA_W-1:0] wr_mask,
`endif
    input  logic              inv_en,
    input  logic              flush_req,
    output logic              ready,
    input  logic              srch_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              rsp_valid,
    output logic              is_hit,
    output logic              multi_hit,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   num_valid
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_key [DEPTH];
`ifdef CAM_TERNARY_EN
    logic [DATA_W-1:0] r_mask [DEPTH];
`endif
    logic              r_ready;
    logic              r_rsp_valid;
    logic              r_is_hit;
    logic              r_multi_hit;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_num_valid;

    logic              w_idle;
    logic              w_addr_ok;
    logic              w_wr;
    logic              w_inv;
    logic              w_lookup;
    logic [DEPTH-1:0]  w_match;
    logic [ADDR_W-1:0] w_hit_addr;
    logic [ADDR_W:0]   w_hit_cnt;
    logic [DEPTH-1:0]  w_valid_nxt;
    logic [ADDR_W:0]   w_valid_cnt;

    assign w_idle    = (r_state == S_IDLE);
    assign w_addr_ok = (int'(wr_addr) < DEPTH);
    // write beats invalidate when both are requested for the same cycle
    assign w_wr      = w_idle & wr_en & w_addr_ok;
    assign w_inv     = w_idle & inv_en & ~wr_en & w_addr_ok;
    assign w_lookup  = w_idle & srch_valid;

    assign ready     = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign is_hit    = r_is_hit;
    assign multi_hit = r_multi_hit;
    assign addr      = r_addr;
    assign num_valid = r_num_valid;

    // per-entry compare against the current (pre-write) table contents
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef CAM_TERNARY_EN
            w_match[i] = r_valid[i] & (((r_key[i] ^ data_in) & r_mask[i]) == '0);
`else
            w_match[i] = r_valid[i] & (r_key[i] == data_in);
`endif
        end
    end

    // lowest matching index and number of matches
    always_comb begin
        w_hit_addr = '0;
        w_hit_cnt  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit_addr = ADDR_W'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_hit_cnt = w_hit_cnt + (ADDR_W+1)'(w_match[i]);
        end
    end

    // next valid vector and its population count, so num_valid tracks the same edge
    always_comb begin
        w_valid_nxt = r_valid;
        w_valid_cnt = '0;
        if (!w_idle) begin
            w_valid_nxt[r_idx] = 1'b0;
        end else if (w_wr) begin
            w_valid_nxt[wr_addr] = 1'b1;
        end else if (w_inv) begin
            w_valid_nxt[wr_addr] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_cnt = w_valid_cnt + (ADDR_W+1)'(w_valid_nxt[i]);
        end
    end

    // FSM, table storage and registered lookup result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_valid     <= '0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_is_hit    <= 1'b0;
            r_multi_hit <= 1'b0;
            r_addr      <= '0;
            r_num_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_key[i] <= '0;
`ifdef CAM_TERNARY_EN
                r_mask[i] <= '1;
`endif
            end
        end else begin
            r_valid     <= w_valid_nxt;
            r_num_valid <= w_valid_cnt;
            r_rsp_valid <= w_lookup;
            if (w_lookup) begin
                r_is_hit    <= |w_match;
                r_multi_hit <= (w_hit_cnt >= (ADDR_W+1)'(2));
                r_addr      <= w_hit_addr;
            end
            if (w_wr) begin
                r_key[wr_addr] <= wr_data;
`ifdef CAM_TERNARY_EN
                r_mask[wr_addr] <= wr_mask;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (flush_req) begin
                        r_state <= S_FLUSH;
                        r_ready <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                S_FLUSH: begin
                    if (r_idx == ADDR_W'(DEPTH - 1)) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_param.sv
// Directed plus randomized bench for cam_param with a table-level reference model.
module tb_cam_param;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk        = 1'b0;
    logic              reset      = 1'b0;
    logic              wr_en      = 1'b0;
    logic              inv_en     = 1'b0;
    logic              flush_req  = 1'b0;
    logic              srch_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr    = '0;
    logic [DATA_W-1:0] wr_data    = '0;
    logic [DATA_W-1:0] data_in    = '0;
`ifdef CAM_TERNARY_EN
    logic [DATA_W-1:0] wr_mask    = '1;
`endif

    logic              ready;
    logic              rsp_valid;
    logic              is_hit;
    logic              multi_hit;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   num_valid;

    int checks   = 0;
    int failures = 0;

    // reference model state: table contents plus flush progress
    bit                m_valid [DEPTH];
    logic [DATA_W-1:0] m_key   [DEPTH];
    logic [DATA_W-1:0] m_mask  [DEPTH];
    int                m_flush_left;
    int                m_flush_idx;
    bit                e_rsp;
    bit                e_hit;
    bit                e_multi;
    int                e_addr;

    cam_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`ifdef CAM_TERNARY_EN
        .wr_mask    (wr_mask),
`endif
        .inv_en     (inv_en),
        .flush_req  (flush_req),
        .ready      (ready),
        .srch_valid (srch_valid),
        .data_in    (data_in),
        .rsp_valid  (rsp_valid),
        .is_hit     (is_hit),
        .multi_hit  (multi_hit),
        .addr       (addr),
        .num_valid  (num_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_key[i]   = '0;
            m_mask[i]  = '1;
        end
        m_flush_left = 0;
        m_flush_idx  = 0;
        e_rsp        = 1'b0;
        e_hit        = 1'b0;
        e_multi      = 1'b0;
        e_addr       = 0;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    // apply one clock edge's worth of the behavioural rules to the model
    task automatic model_edge();
        bit idle = (m_flush_left == 0);
        if (idle && srch_valid) begin
            int hits[$];
            for (int i = 0; i < DEPTH; i++)
                if (m_valid[i] && (((m_key[i] ^ data_in) & m_mask[i]) == '0))
                    hits.push_back(i);
            e_rsp   = 1'b1;
            e_hit   = (hits.size() > 0);
            e_multi = (hits.size() >= 2);
            e_addr  = e_hit ? hits[0] : 0;
        end else begin
            e_rsp = 1'b0;
        end
        if (idle) begin
            if (wr_en) begin
                m_valid[wr_addr] = 1'b1;
                m_key[wr_addr]   = wr_data;
`ifdef CAM_TERNARY_EN
                m_mask[wr_addr]  = wr_mask;
`else
                m_mask[wr_addr]  = '1;
`endif
            end else if (inv_en) begin
                m_valid[wr_addr] = 1'b0;
            end
            if (flush_req) begin
                m_flush_left = DEPTH;
                m_flush_idx  = 0;
            end
        end else begin
            m_valid[m_flush_idx] = 1'b0;
            m_flush_idx++;
            m_flush_left--;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ready"},     {7'd0, ready},     {7'd0, (m_flush_left == 0)});
        check({tag, ".rsp_valid"}, {7'd0, rsp_valid}, {7'd0, e_rsp});
        check({tag, ".is_hit"},    {7'd0, is_hit},    {7'd0, e_hit});
        check({tag, ".multi_hit"}, {7'd0, multi_hit}, {7'd0, e_multi});
        check({tag, ".addr"},      8'(addr),          8'(e_addr));
        check({tag, ".num_valid"}, 8'(num_valid),     8'(model_count()));
    endtask

    // drive one cycle of inputs, advance the model and the DUT, then compare
    task automatic do_op(input string tag, input bit we, input bit ie, input bit fr,
                         input bit sv, input int a, input int d, input int k, input int m);
        wr_en      = we;
        inv_en     = ie;
        flush_req  = fr;
        srch_valid = sv;
        wr_addr    = ADDR_W'(a);
        wr_data    = DATA_W'(d);
        data_in    = DATA_W'(k);
`ifdef CAM_TERNARY_EN
        wr_mask    = DATA_W'(m);
`else
        if (m < 0) $display("unused mask argument");
`endif
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst.ready",     {7'd0, ready},     8'd1);
        check("rst.rsp_valid", {7'd0, rsp_valid}, 8'd0);
        check("rst.is_hit",    {7'd0, is_hit},    8'd0);
        check("rst.addr",      8'(addr),          8'd0);
        check("rst.num_valid", 8'(num_valid),     8'd0);
        reset = 1'b1;

        do_op("look_empty", 0, 0, 0, 1, 0, 0, 'hB, 'hF);
        check("look_empty.c_rsp", {7'd0, rsp_valid}, 8'd1);
        check("look_empty.c_hit", {7'd0, is_hit},    8'd0);

        do_op("wr0", 1, 0, 0, 0, 0, 'hB, 0, 'hF);
        do_op("wr1", 1, 0, 0, 0, 1, 'hB, 0, 'hF);
        do_op("wr2", 1, 0, 0, 0, 2, 'hE, 0, 'hF);
        do_op("wr3", 1, 0, 0, 0, 3, 'h1, 0, 'hF);
        check("wr3.c_num", 8'(num_valid), 8'd4);
        do_op("lookB", 0, 0, 0, 1, 0, 0, 'hB, 'hF);
        check("lookB.c_hit",   {7'd0, is_hit},    8'd1);
        check("lookB.c_multi", {7'd0, multi_hit}, 8'd1);
        check("lookB.c_addr",  8'(addr),          8'd0);
        do_op("look1", 0, 0, 0, 1, 0, 0, 'h1, 'hF);
        check("look1.c_addr",  8'(addr),          8'd3);
        check("look1.c_multi", {7'd0, multi_hit}, 8'd0);

        do_op("wr_look", 1, 0, 0, 1, 2, 'h7, 'hE, 'hF);
        check("wr_look.c_hit",  {7'd0, is_hit}, 8'd1);
        check("wr_look.c_addr", 8'(addr),       8'd2);
        do_op("lookE", 0, 0, 0, 1, 0, 0, 'hE, 'hF);
        check("lookE.c_hit",  {7'd0, is_hit}, 8'd0);

        do_op("rewrite", 1, 0, 0, 0, 2, 'h7, 0, 'hF);
        check("rewrite.c_num", 8'(num_valid), 8'd4);
        do_op("wr_inv", 1, 1, 0, 0, 3, 'h1, 0, 'hF);
        check("wr_inv.c_num", 8'(num_valid), 8'd4);

        do_op("flush_go", 0, 0, 1, 1, 0, 0, 'h7, 'hF);
        check("flush_go.c_hit", {7'd0, is_hit}, 8'd1);
        for (int c = 0; c < DEPTH - 1; c++) begin
            do_op("flushing", 1, 1, 1, 1, 1, 'h3, 'h3, 'hF);
            check("flushing.c_ready", {7'd0, ready}, 8'd0);
        end
        do_op("flush_end", 0, 0, 0, 0, 0, 0, 0, 'hF);
        check("flush_end.c_ready", {7'd0, ready},   8'd1);
        check("flush_end.c_num",   8'(num_valid),   8'd0);
        do_op("post_flushB", 0, 0, 0, 1, 0, 0, 'hB, 'hF);
        check("post_flushB.c_hit", {7'd0, is_hit}, 8'd0);
        do_op("post_flush3", 0, 0, 0, 1, 0, 0, 'h3, 'hF);
        check("post_flush3.c_hit", {7'd0, is_hit}, 8'd0);

        for (int i = 0; i < DEPTH; i++) do_op("refill", 1, 0, 0, 0, i, i + 5, 0, 'hF);
        do_op("look6", 0, 0, 0, 1, 0, 0, 'h6, 'hF);
        check("look6.c_addr", 8'(addr), 8'd1);
        do_op("flush2_go", 0, 0, 1, 0, 0, 0, 0, 'hF);
        do_op("flush2_c1", 0, 0, 0, 0, 0, 0, 0, 'hF);
        #2;
        reset = 1'b0;
        #1;
        check("midrst.ready",     {7'd0, ready},     8'd1);
        check("midrst.num_valid", 8'(num_valid),     8'd0);
        check("midrst.rsp_valid", {7'd0, rsp_valid}, 8'd0);
        check("midrst.is_hit",    {7'd0, is_hit},    8'd0);
        check("midrst.multi_hit", {7'd0, multi_hit}, 8'd0);
        check("midrst.addr",      8'(addr),          8'd0);
        model_reset();
        #2;
        reset = 1'b1;
        do_op("after_rst", 0, 0, 0, 1, 0, 0, 'h6, 'hF);
        check("after_rst.c_hit", {7'd0, is_hit}, 8'd0);

`ifdef CAM_TERNARY_EN
        do_op("tern_wr", 1, 0, 0, 0, 0, 'b1000, 0, 'b1000);
        do_op("tern_hit", 0, 0, 0, 1, 0, 0, 'b1011, 'hF);
        check("tern_hit.c_hit",  {7'd0, is_hit}, 8'd1);
        check("tern_hit.c_addr", 8'(addr),       8'd0);
        do_op("tern_miss", 0, 0, 0, 1, 0, 0, 'b0011, 'hF);
        check("tern_miss.c_hit", {7'd0, is_hit}, 8'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            do_op("rand",
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
